// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit
//   Iterative multiply/divide unit for the HI/LO path. Operands are captured
//   when a request is accepted. One multiplier or quotient bit is processed
//   per cycle. A final FIX cycle applies sign correction and registers the
//   result.
//
// Ports
//   clock        : rising-edge clock
//   clear        : synchronous active-high reset
//   start        : request, sampled only while idle
//   op[1:0]      : 00 MUL (signed), 01 MULU, 10 DIV (signed), 11 DIVU
//   a, b         : multiplicand/dividend and multiplier/divisor
//   hi, lo       : product high/low half, or remainder/quotient
//   busy         : high whenever the unit is not idle
//   done         : one-cycle completion pulse; hi/lo/div_by_zero valid from here
//   div_by_zero  : set together with done for a divide whose divisor was zero
//   dbg_state    : current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// unit is idle. Nothing is queued. Any start seen while busy is dropped. The
// result appears on hi/lo when done pulses, and it holds until the next
// operation finishes.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_t state, state_next;

  // Captured operation context
  logic [1:0]         op_q;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               dbz_q;
  logic [CW-1:0]      cnt;

  // Multiply accumulator: upper half is the running sum. The lower half
  // starts as the multiplier and is shifted out one bit per cycle.
  logic [2*WIDTH-1:0] acc;

  // Divide state: rem is the partial remainder. quo starts as the dividend
  // and fills with quotient bits from the right as dividend bits shift out.
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;

  // Input-side magnitude capture. Only the signed ops take magnitudes.
  logic               a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;

  assign a_neg_in = ~op[0] & a[WIDTH-1];
  assign b_neg_in = ~op[0] & b[WIDTH-1];
  assign a_mag_in = a_neg_in ? (~a + 1'b1) : a;
  assign b_mag_in = b_neg_in ? (~b + 1'b1) : b;

  // One shift-add step
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

  // One restoring-division step
  logic [WIDTH+1:0]   div_shift;
  logic               div_ok;
  logic [WIDTH:0]     div_diff;
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_ok    = (div_shift >= {2'b00, mag_b});
  assign div_diff  = div_shift[WIDTH:0] - {1'b0, mag_b};

  // Sign correction applied in FIX
  logic               is_signed_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, a_restored;

  assign is_signed_q = ~op_q[0];
  assign prod_fix    = (is_signed_q && (neg_a ^ neg_b)) ? (~acc + 1'b1) : acc;
  assign quo_fix     = (is_signed_q && (neg_a ^ neg_b)) ? (~quo + 1'b1) : quo;
  assign rem_fix     = (is_signed_q && neg_a) ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
  // Divide-by-zero returns the original dividend. Re-negating the magnitude
  // gives it back, and MIN maps to itself.
  assign a_restored  = neg_a ? (~mag_a + 1'b1) : mag_a;

  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (op[1] && (b == '0)) ? S_FIX : S_CALC;
      S_CALC: if (cnt == '0) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      op_q        <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      dbz_q       <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      rem         <= '0;
      quo         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      // busy and done are flopped from the next state, so they line up with
      // the state register and have no input-to-output path.
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            neg_a <= a_neg_in;
            neg_b <= b_neg_in;
            mag_a <= a_mag_in;
            mag_b <= b_mag_in;
            dbz_q <= op[1] && (b == '0);
            cnt   <= CNT_LOAD;
            acc   <= {{WIDTH{1'b0}}, b_mag_in};
            rem   <= '0;
            quo   <= a_mag_in;
          end
        end
        S_CALC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (op_q[1]) begin
            rem <= div_ok ? div_diff : div_shift[WIDTH:0];
            quo <= {quo[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          div_by_zero <= dbz_q;
          if (dbz_q) begin
            hi <= a_restored;
            lo <= '1;
          end else if (op_q[1]) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
module tb_seq_muldiv_unit;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  // ---------------- clock / reset ----------------
  logic clock_tb = 1'b0;
  always #5 clock_tb = ~clock_tb;

  logic clear;

  // WIDTH=32 instance
  logic        start32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        busy32, done32, dbz32;
  logic [1:0]  st32;

  // WIDTH=8 instance
  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dbz8;
  logic [1:0]  st8;

  seq_muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock_tb), .clear(clear), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_by_zero(dbz32),
    .dbg_state(st32)
  );

  seq_muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock_tb), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .dbg_state(st8)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard queues: {div_by_zero, hi, lo}
  logic [64:0] exp32_q[$];
  logic [16:0] exp8_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built on 64-bit arithmetic
  function automatic logic [64:0] model32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    logic [63:0] r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model32 = '0;
    case (op)
      OP_MUL:  begin sp = sa * sb; r64 = sp; model32 = {1'b0, r64}; end
      OP_MULU: begin up = ua * ub; r64 = up; model32 = {1'b0, r64}; end
      OP_DIV: begin
        if (b == 32'd0) model32 = {1'b1, a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          r64 = {sr[31:0], sq[31:0]};
          model32 = {1'b0, r64};
        end
      end
      default: begin
        if (b == 32'd0) model32 = {1'b1, a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub; ur = ua % ub;
          r64 = {ur[31:0], uq[31:0]};
          model32 = {1'b0, r64};
        end
      end
    endcase
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clock_tb) begin
    if (done32) begin
      checks++;
      if (exp32_q.size() == 0) begin
        errors++;
        $display("FAIL done32_unexpected: got done=1 expected no pending result");
      end else begin
        logic [64:0] e;
        e = exp32_q.pop_front();
        if ({dbz32, hi32, lo32} !== e) begin
          errors++;
          $display("FAIL result32: got dbz=%b hi=%h lo=%h expected dbz=%b hi=%h lo=%h",
                   dbz32, hi32, lo32, e[64], e[63:32], e[31:0]);
        end
      end
    end
    if (done8) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: got done=1 expected no pending result");
      end else begin
        logic [16:0] e8;
        e8 = exp8_q.pop_front();
        if ({dbz8, hi8, lo8} !== e8) begin
          errors++;
          $display("FAIL result8: got dbz=%b hi=%h lo=%h expected dbz=%b hi=%h lo=%h",
                   dbz8, hi8, lo8, e8[16], e8[15:8], e8[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request, scramble the inputs after acceptance, then check
  // latency, busy and the return to idle.
  task automatic do_op32(input string name, input logic [1:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [64:0] exp, input int lat);
    int n;
    logic busy_ok;
    @(negedge clock_tb);
    op32 = op; a32 = av; b32 = bv; start32 = 1'b1;
    @(posedge clock_tb); #1;
    start32 = 1'b0;
    op32 = 2'($urandom_range(0, 3)); a32 = $urandom; b32 = $urandom;
    exp32_q.push_back(exp);
    n = 0; busy_ok = 1'b1;
    while (!done32 && n < 200) begin
      if (!busy32) busy_ok = 1'b0;
      @(posedge clock_tb); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_busy"}, {63'd0, busy_ok & busy32}, 64'd1);
    @(posedge clock_tb); #1;
    chk({name, "_idle"}, {60'd0, done32, busy32, st32}, 64'd0);
  endtask

  task automatic do_op8(input string name, input logic [1:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [16:0] exp, input int lat);
    int n;
    @(negedge clock_tb);
    op8 = op; a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clock_tb); #1;
    start8 = 1'b0;
    op8 = 2'($urandom_range(0, 3)); a8 = 8'($urandom); b8 = 8'($urandom);
    exp8_q.push_back(exp);
    n = 0;
    while (!done8 && n < 100) begin
      @(posedge clock_tb); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    @(posedge clock_tb); #1;
    chk({name, "_idle"}, {60'd0, done8, busy8, st8}, 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    int seen;
    vecs[0]  = '{"mul_15x10",   OP_MUL,  32'd15,        32'd10,        1'b0, 32'h0000_0000, 32'h0000_0096, 33};
    vecs[1]  = '{"mul_m7x3",    OP_MUL,  -32'sd7,       32'd3,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    vecs[2]  = '{"mulu_max",    OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[3]  = '{"div_m7d2",    OP_DIV,  -32'sd7,       32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4]  = '{"div_min_m1",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[5]  = '{"divu_100d7",  OP_DIVU, 32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        33};
    vecs[6]  = '{"divu_by0",    OP_DIVU, 32'd100,       32'd0,         1'b1, 32'h0000_0064, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{"mul_2x3",     OP_MUL,  32'd2,         32'd3,         1'b0, 32'h0000_0000, 32'h0000_0006, 33};
    vecs[8]  = '{"div_7dm2",    OP_DIV,  32'd7,         -32'sd2,       1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[9]  = '{"div_m8dm3",   OP_DIV,  -32'sd8,       -32'sd3,       1'b0, 32'hFFFF_FFFE, 32'h0000_0002, 33};
    vecs[10] = '{"mul_min_min", OP_MUL,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 33};
    vecs[11] = '{"div_m5_by0",  OP_DIV,  -32'sd5,       32'd0,         1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};

    clear = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clock_tb);
    #1;
    chk("reset32", {25'd0, hi32, lo32, busy32, done32, dbz32, st32}, 64'd0);
    chk("reset8",  {41'd0, hi8, lo8, busy8, done8, dbz8, st8}, 64'd0);
    clear = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++)
      do_op32(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
              {vecs[i].dbz, vecs[i].hi, vecs[i].lo}, vecs[i].lat);

    // Results hold while idle
    repeat (5) @(posedge clock_tb);
    #1;
    chk("hold32", {31'd0, dbz32, hi32, lo32}, {31'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // Random vectors against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      do_op32("rand", rop, ra, rb, model32(rop, ra, rb), (rop[1] && rb == 32'd0) ? 1 : 33);
    end

    // A start pulse during CALC is dropped
    @(negedge clock_tb);
    op32 = OP_MUL; a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
    @(posedge clock_tb); #1;
    start32 = 1'b0;
    exp32_q.push_back({1'b0, 32'd0, 32'd25});
    n = 0;
    repeat (3) begin @(posedge clock_tb); #1; n++; end
    start32 = 1'b1; op32 = OP_MULU; a32 = 32'd9; b32 = 32'd9;
    @(posedge clock_tb); #1; n++;
    start32 = 1'b0;
    while (!done32 && n < 200) begin @(posedge clock_tb); #1; n++; end
    chk("ignored_start_latency", 64'(n), 64'd33);
    @(posedge clock_tb); #1;
    chk("ignored_start_idle", {62'd0, st32}, 64'd0);

    // clear in the middle of CALC
    @(negedge clock_tb);
    op32 = OP_MUL; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
    @(posedge clock_tb); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clock_tb);
    @(negedge clock_tb);
    clear = 1'b1;
    @(posedge clock_tb); #1;
    clear = 1'b0;
    chk("clear_mid_calc", {25'd0, hi32, lo32, busy32, done32, dbz32, st32}, 64'd0);
    repeat (40) @(posedge clock_tb);
    #1;
    chk("clear_stays_idle", {62'd0, busy32, done32}, 64'd0);
    do_op32("mul_6x7", OP_MUL, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42}, 33);

    // Back-to-back accepts with start held high
    @(negedge clock_tb);
    op32 = OP_MUL; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
    @(posedge clock_tb); #1;
    exp32_q.push_back({1'b0, 32'd0, 32'd12});
    exp32_q.push_back({1'b0, 32'd0, 32'd12});
    n = 0; seen = 0;
    while (seen < 2 && n < 300) begin
      @(posedge clock_tb); #1;
      n++;
      if (done32) begin
        seen++;
        if (seen == 1) chk("b2b_first_latency", 64'(n), 64'd33);
        else           chk("b2b_second_latency", 64'(n), 64'd68);
      end
    end
    start32 = 1'b0;
    chk("b2b_done_count", 64'(seen), 64'd2);
    repeat (2) @(posedge clock_tb);
    #1;
    chk("b2b_idle", {62'd0, st32}, 64'd0);

    // WIDTH=8 instance
    do_op8("w8_mul_15x10", OP_MUL, 8'd15, 8'd10, {1'b0, 8'h00, 8'h96}, 9);
    do_op8("w8_mul_m7x3",  OP_MUL, 8'hF9, 8'd3,  {1'b0, 8'hFF, 8'hEB}, 9);
    do_op8("w8_div_m7d2",  OP_DIV, 8'hF9, 8'd2,  {1'b0, 8'hFF, 8'hFD}, 9);
    do_op8("w8_divu_by0",  OP_DIVU, 8'd100, 8'd0, {1'b1, 8'h64, 8'hFF}, 1);

    repeat (3) @(posedge clock_tb);
    #1;
    chk("queue32_empty", 64'(exp32_q.size()), 64'd0);
    chk("queue8_empty",  64'(exp8_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
